// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - states, phase durations and green-time helper for the lane scheduler
package traffic_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GREEN   = 3'd1,
        S_YELLOW  = 3'd2,
        S_ALL_RED = 3'd3,
        S_WALK    = 3'd4,
        S_EMG     = 3'd5
    } state_t;

    localparam int T_YELLOW    = 3;
    localparam int T_ALLRED    = 1;
    localparam int T_WALK      = 10;
    localparam int GREEN_MIN   = 5;
    localparam int GREEN_MAX   = 60;
    localparam int SEC_PER_CAR = 2;

    localparam logic [6:0] LOAD_YELLOW = 7'(T_YELLOW - 1);
    localparam logic [6:0] LOAD_ALLRED = 7'(T_ALLRED - 1);
    localparam logic [6:0] LOAD_WALK   = 7'(T_WALK - 1);

    // Timer load value for a green phase: clamp(cars*2, min, max) - 1; 255*2 fits in 9 bits.
    function automatic logic [6:0] green_load(input logic [7:0] cars);
        logic [8:0] dur;
        dur = 9'(cars) * 9'(SEC_PER_CAR);
        if (dur < 9'(GREEN_MIN)) begin
            dur = 9'(GREEN_MIN);
        end else if (dur > 9'(GREEN_MAX)) begin
            dur = 9'(GREEN_MAX);
        end
        return 7'(dur - 9'd1);
    endfunction

endpackage

// File: rtl/rr_lane_finder.sv
// rtl/rr_lane_finder.sv - combinational round-robin search for the next busy lane
module rr_lane_finder (
    input  logic [7:0] req_i,
    input  logic [2:0] ptr_i,
    output logic [2:0] idx_o,
    output logic       found_o
);

    logic [2:0] cand;

    // Walk from farthest to nearest so the nearest lane after ptr_i wins; ptr_i itself is last.
    always_comb begin
        idx_o   = ptr_i;
        found_o = 1'b0;
        cand    = ptr_i;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr_i + 3'(k + 1);
            if (req_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_scheduler.sv
// rtl/lane_scheduler.sv - eight-lane traffic phase sequencer with pedestrian and emergency service
module lane_scheduler
    import traffic_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0][7:0] lanes,
    input  logic            ped_req,
    input  logic            emg_req,
    input  logic [2:0]      emg_lane,
    input  logic            timer_zero,
    output logic            timer_load,
    output logic [6:0]      timer_load_val,
    output logic [7:0]      green,
    output logic [7:0]      yellow,
    output logic [7:0]      red,
    output logic            walk,
    output logic [2:0]      state,
    output logic [2:0]      lane
);

    state_t     state_q, state_d;
    logic [2:0] lane_q, lane_d;
    logic       ped_q, ped_d;
    logic       load_d;
    logic [6:0] load_val_d;

    logic [7:0] busy;
    logic [2:0] nxt_lane;
    logic       nxt_found;
    logic [6:0] nxt_green_load;
    logic [7:0] lane_onehot;

    always_comb begin
        busy = '0;
        for (int i = 0; i < 8; i++) begin
            busy[i] = |lanes[i];
        end
    end

    rr_lane_finder u_finder (
        .req_i   (busy),
        .ptr_i   (lane_q),
        .idx_o   (nxt_lane),
        .found_o (nxt_found)
    );

    assign nxt_green_load = green_load(lanes[nxt_lane]);

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        ped_d      = ped_q | ped_req;
        load_d     = 1'b0;
        load_val_d = '0;
        case (state_q)
            S_IDLE: begin
                if (nxt_found) begin
                    state_d    = S_GREEN;
                    lane_d     = nxt_lane;
                    load_d     = 1'b1;
                    load_val_d = nxt_green_load;
                end
            end
            S_GREEN: begin
                if (emg_req && (emg_lane == lane_q)) begin
                    state_d = S_EMG;
                end else if (emg_req || timer_zero) begin
                    state_d    = S_YELLOW;
                    load_d     = 1'b1;
                    load_val_d = LOAD_YELLOW;
                end
            end
            S_YELLOW: begin
                if (timer_zero) begin
                    state_d    = S_ALL_RED;
                    load_d     = 1'b1;
                    load_val_d = LOAD_ALLRED;
                end
            end
            S_ALL_RED: begin
                // Emergency outranks a waiting pedestrian; the pedestrian stays latched for later.
                if (timer_zero) begin
                    if (emg_req) begin
                        state_d = S_EMG;
                        lane_d  = emg_lane;
                    end else if (ped_q || ped_req) begin
                        state_d    = S_WALK;
                        ped_d      = 1'b0;
                        load_d     = 1'b1;
                        load_val_d = LOAD_WALK;
                    end else if (nxt_found) begin
                        state_d    = S_GREEN;
                        lane_d     = nxt_lane;
                        load_d     = 1'b1;
                        load_val_d = nxt_green_load;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WALK: begin
                if (emg_req) begin
                    state_d    = S_ALL_RED;
                    load_d     = 1'b1;
                    load_val_d = LOAD_ALLRED;
                end else if (timer_zero) begin
                    if (nxt_found) begin
                        state_d    = S_GREEN;
                        lane_d     = nxt_lane;
                        load_d     = 1'b1;
                        load_val_d = nxt_green_load;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_EMG: begin
                if (!emg_req || (emg_lane != lane_q)) begin
                    state_d    = S_YELLOW;
                    load_d     = 1'b1;
                    load_val_d = LOAD_YELLOW;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lane_q  <= 3'd7;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            ped_q   <= ped_d;
        end
    end

    // Lamps are forced safe while reset is held, before the reset edge lands.
    assign lane_onehot    = 8'd1 << lane_q;
    assign green          = (!rst && (state_q == S_GREEN || state_q == S_EMG)) ? lane_onehot : 8'h00;
    assign yellow         = (!rst && (state_q == S_YELLOW)) ? lane_onehot : 8'h00;
    assign red            = ~(green | yellow);
    assign walk           = !rst && (state_q == S_WALK);
    assign timer_load     = !rst && load_d;
    assign timer_load_val = rst ? 7'd0 : load_val_d;
    assign state          = state_q;
    assign lane           = lane_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// tb/tb_lane_scheduler.sv - directed bench for lane_scheduler with a saturation timer model
module tb_lane_scheduler;
    import traffic_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0][7:0] lanes = '0;
    logic            ped_req = 1'b0;
    logic            emg_req = 1'b0;
    logic [2:0]      emg_lane = 3'd0;
    logic            timer_zero;
    logic            timer_load;
    logic [6:0]      timer_load_val;
    logic [7:0]      green, yellow, red;
    logic            walk;
    logic [2:0]      state, lane;

    lane_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .lanes          (lanes),
        .ped_req        (ped_req),
        .emg_req        (emg_req),
        .emg_lane       (emg_lane),
        .timer_zero     (timer_zero),
        .timer_load     (timer_load),
        .timer_load_val (timer_load_val),
        .green          (green),
        .yellow         (yellow),
        .red            (red),
        .walk           (walk),
        .state          (state),
        .lane           (lane)
    );

    always #5 clk = ~clk;

    logic [6:0] tcount;
    assign timer_zero = (tcount == 7'd0);
    always @(posedge clk) begin
        if (rst)                 tcount <= 7'd0;
        else if (timer_load)     tcount <= timer_load_val;
        else if (tcount != 7'd0) tcount <= tcount - 7'd1;
    end

    logic [6:0] last_load = 7'd0;
    int         loads_seen = 0;
    always @(posedge clk) begin
        if (timer_load) begin
            last_load  <= timer_load_val;
            loads_seen <= loads_seen + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        lanes    = '0;
        ped_req  = 1'b0;
        emg_req  = 1'b0;
        emg_lane = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_green(input string name, input int limit);
        int n;
        n = 0;
        while (green == 8'h00 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (green == 8'h00) check({name, "_wait_green"}, 0, 1);
    endtask

    // Counts consecutive samples matching the lamp pattern, starting with the current one.
    task automatic count_phase(input logic [7:0] g, input logic [7:0] y, input logic w,
                               input int limit, output int n);
        n = 0;
        while (green == g && yellow == y && walk == w && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int idx;
        int cars;
        int dur;
    } vec_t;

    vec_t vecs[9];
    int   n;
    int   base;
    logic [7:0] eg;

    initial begin
        vecs[0] = '{2, 4, 8};
        vecs[1] = '{0, 40, 60};
        vecs[2] = '{0, 1, 5};
        vecs[3] = '{3, 2, 5};
        vecs[4] = '{6, 3, 6};
        vecs[5] = '{7, 30, 60};
        vecs[6] = '{5, 255, 60};
        vecs[7] = '{4, 29, 58};
        vecs[8] = '{1, 31, 60};

        @(negedge clk);
        check("rst_green", green, 8'h00);
        check("rst_yellow", yellow, 8'h00);
        check("rst_red", red, 8'hFF);
        check("rst_walk", walk, 0);
        check("rst_load", timer_load, 0);
        check("rst_load_val", timer_load_val, 0);
        check("rst_lane", lane, 7);
        check("rst_state", state, S_IDLE);

        rst  = 1'b0;
        base = loads_seen;
        repeat (50) @(negedge clk);
        check("idle_state", state, S_IDLE);
        check("idle_red", red, 8'hFF);
        check("idle_no_load", loads_seen - base, 0);

        for (int v = 0; v < 9; v++) begin
            do_reset();
            lanes[vecs[v].idx] = 8'(vecs[v].cars);
            eg = 8'd1 << vecs[v].idx;
            wait_green("vec", 20);
            check($sformatf("vec%0d_green", v), green, eg);
            check($sformatf("vec%0d_load", v), last_load, vecs[v].dur - 1);
            count_phase(eg, 8'h00, 1'b0, 100, n);
            check($sformatf("vec%0d_green_len", v), n, vecs[v].dur);
            count_phase(8'h00, eg, 1'b0, 10, n);
            check($sformatf("vec%0d_yellow_len", v), n, 3);
            count_phase(8'h00, 8'h00, 1'b0, 10, n);
            check($sformatf("vec%0d_allred_len", v), n, 1);
            check($sformatf("vec%0d_regreen", v), green, eg);
        end

        do_reset();
        lanes[1] = 8'd3;
        lanes[5] = 8'd3;
        wait_green("rr", 20);
        check("rr_first", green, 8'h02);
        count_phase(8'h02, 8'h00, 1'b0, 100, n);
        count_phase(8'h00, 8'h02, 1'b0, 10, n);
        count_phase(8'h00, 8'h00, 1'b0, 10, n);
        check("rr_second", green, 8'h20);
        count_phase(8'h20, 8'h00, 1'b0, 100, n);
        count_phase(8'h00, 8'h20, 1'b0, 10, n);
        count_phase(8'h00, 8'h00, 1'b0, 10, n);
        check("rr_third", green, 8'h02);

        do_reset();
        lanes[2] = 8'd4;
        wait_green("ped", 20);
        repeat (2) @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        count_phase(8'h04, 8'h00, 1'b0, 100, n);
        count_phase(8'h00, 8'h04, 1'b0, 10, n);
        count_phase(8'h00, 8'h00, 1'b0, 10, n);
        check("ped_allred_len", n, 1);
        check("ped_walk", walk, 1);
        check("ped_red", red, 8'hFF);
        count_phase(8'h00, 8'h00, 1'b1, 30, n);
        check("ped_walk_len", n, 10);
        check("ped_next_green", green, 8'h04);

        do_reset();
        lanes[1] = 8'd3;
        lanes[5] = 8'd3;
        wait_green("emg", 20);
        @(negedge clk);
        emg_lane = 3'd3;
        emg_req  = 1'b1;
        @(negedge clk);
        check("emg_cut_yellow", yellow, 8'h02);
        count_phase(8'h00, 8'h02, 1'b0, 10, n);
        check("emg_yellow_len", n, 3);
        count_phase(8'h00, 8'h00, 1'b0, 10, n);
        check("emg_allred_len", n, 1);
        count_phase(8'h08, 8'h00, 1'b0, 20, n);
        check("emg_green_held", n, 20);
        check("emg_state", state, S_EMG);
        emg_lane = 3'd6;
        @(negedge clk);
        check("emg_move_yellow", yellow, 8'h08);
        count_phase(8'h00, 8'h08, 1'b0, 10, n);
        check("emg_move_yellow_len", n, 3);
        count_phase(8'h00, 8'h00, 1'b0, 10, n);
        check("emg_move_allred_len", n, 1);
        check("emg_move_green", green, 8'h40);
        emg_req = 1'b0;
        @(negedge clk);
        check("emg_drop_yellow", yellow, 8'h40);

        do_reset();
        lanes[1] = 8'd3;
        wait_green("emg_same", 20);
        emg_lane = 3'd1;
        emg_req  = 1'b1;
        @(negedge clk);
        check("emg_same_state", state, S_EMG);
        count_phase(8'h02, 8'h00, 1'b0, 20, n);
        check("emg_same_held", n, 20);
        emg_req = 1'b0;
        @(negedge clk);
        check("emg_same_drop", yellow, 8'h02);

        do_reset();
        lanes[2] = 8'd4;
        wait_green("midrst", 20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_green_now", green, 8'h00);
        check("midrst_red_now", red, 8'hFF);
        @(negedge clk);
        check("midrst_state", state, S_IDLE);
        check("midrst_yellow", yellow, 8'h00);
        check("midrst_lane", lane, 7);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
